// File: rtl/tmds_decoder.sv
// TMDS channel decoder: bit-slip alignment on control tokens, token/data decode,
// and lock supervision with a token-loss timeout.
module tmds_decoder #(
    parameter int MIN_TOKENS = 8,
    parameter int TIMEOUT    = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] raw,
    output logic       de,
    output logic [1:0] cd,
    output logic [7:0] vd,
    output logic       locked,
    output logic [3:0] offset
);

    localparam int CNT_W = $clog2(MIN_TOKENS + 1);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MIN_TOKENS);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } state_t;

    function automatic logic tok_valid(input logic [9:0] s);
        case (s)
            10'b1101010100, 10'b0010101011,
            10'b0101010100, 10'b1010101011: tok_valid = 1'b1;
            default:                        tok_valid = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] tok_cd(input logic [9:0] s);
        case (s)
            10'b1101010100: tok_cd = 2'b00;
            10'b0010101011: tok_cd = 2'b01;
            10'b0101010100: tok_cd = 2'b10;
            10'b1010101011: tok_cd = 2'b11;
            default:        tok_cd = 2'b00;
        endcase
    endfunction

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    function automatic logic [7:0] data_dec(input logic [9:0] s);
        logic [7:0] d;
        logic [7:0] v;
        d    = s[9] ? ~s[7:0] : s[7:0];
        v    = 8'h00;
        v[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            v[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
        return v;
    endfunction

    function automatic logic [3:0] next_offset(input logic [3:0] o);
        return (o == 4'd9) ? 4'd0 : o + 4'd1;
    endfunction

    logic [9:0]       cur_r;
    logic [9:0]       prev_r;
    logic [9:0]       sym_r;
    logic [2:0]       rst_sync_r;
    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [TMO_W-1:0] tmo_r;
    logic [3:0]       offset_r;
    logic             de_r;
    logic [1:0]       cd_r;
    logic [7:0]       vd_r;
    logic             locked_r;

    logic [19:0]      window_s;
    logic [4:0]       idx_s;
    logic             run_s;
    logic             tok_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [TMO_W-1:0] tmo_inc_s;
    state_t           state_nx_s;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [TMO_W-1:0] tmo_nx_s;
    logic [3:0]       offset_nx_s;
    logic             de_nx_s;
    logic [1:0]       cd_nx_s;
    logic [7:0]       vd_nx_s;

    assign window_s  = {cur_r, prev_r};
    assign idx_s     = {1'b0, offset_r};
    assign run_s     = rst_sync_r[2];
    assign tok_s     = tok_valid(sym_r);
    assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
    assign tmo_inc_s = (tmo_r == TMO_MAX) ? tmo_r : tmo_r + TMO_W'(1);

    // Three-stage release also covers the pipeline fill, so the first
    // evaluated symbol is a real received word rather than reset zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync_r <= 3'b000;
        end else begin
            rst_sync_r <= {rst_sync_r[1:0], 1'b1};
        end
    end

    // Input word pipeline and bit-offset symbol extraction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_r  <= 10'd0;
            prev_r <= 10'd0;
            sym_r  <= 10'd0;
        end else begin
            cur_r  <= raw;
            prev_r <= cur_r;
            sym_r  <= window_s[idx_s +: 10];
        end
    end

    // Alignment state machine next-state and next-output logic.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        tmo_nx_s    = tmo_r;
        offset_nx_s = offset_r;
        de_nx_s     = 1'b0;
        cd_nx_s     = 2'b00;
        vd_nx_s     = 8'h00;
        if (run_s) begin
            case (state_r)
                SEARCH: begin
                    if (tok_s) begin
                        state_nx_s = VERIFY;
                        cnt_nx_s   = CNT_W'(1);
                    end else begin
                        state_nx_s  = SLIP;
                        offset_nx_s = next_offset(offset_r);
                    end
                end
                SLIP: begin
                    state_nx_s = SEARCH;
                end
                VERIFY: begin
                    if (tok_s) begin
                        cnt_nx_s = cnt_inc_s;
                        if (cnt_inc_s >= CNT_MAX) begin
                            state_nx_s = LOCKED;
                            tmo_nx_s   = TMO_W'(0);
                        end else begin
                            state_nx_s = VERIFY;
                        end
                    end else begin
                        state_nx_s  = SLIP;
                        offset_nx_s = next_offset(offset_r);
                    end
                end
                LOCKED: begin
                    if (tok_s) begin
                        tmo_nx_s = TMO_W'(0);
                    end else begin
                        tmo_nx_s = tmo_inc_s;
                        if (tmo_inc_s >= TMO_MAX) begin
                            state_nx_s = SEARCH;
                            cnt_nx_s   = CNT_W'(0);
                        end else begin
                            state_nx_s = LOCKED;
                        end
                    end
                end
                default: begin
                    state_nx_s = SEARCH;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
        // Outputs follow the state being entered so locked and the first
        // locked symbol appear together, and drop together on timeout.
        if (state_nx_s == LOCKED) begin
            if (tok_s) begin
                cd_nx_s = tok_cd(sym_r);
            end else begin
                de_nx_s = 1'b1;
                cd_nx_s = cd_r;
                vd_nx_s = data_dec(sym_r);
            end
        end else begin
            de_nx_s = 1'b0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= SEARCH;
            cnt_r    <= CNT_W'(0);
            tmo_r    <= TMO_W'(0);
            offset_r <= 4'd0;
            de_r     <= 1'b0;
            cd_r     <= 2'b00;
            vd_r     <= 8'h00;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            cnt_r    <= cnt_nx_s;
            tmo_r    <= tmo_nx_s;
            offset_r <= offset_nx_s;
            de_r     <= de_nx_s;
            cd_r     <= cd_nx_s;
            vd_r     <= vd_nx_s;
            locked_r <= (state_nx_s == LOCKED);
        end
    end

    assign de     = de_r;
    assign cd     = cd_r;
    assign vd     = vd_r;
    assign locked = locked_r;
    assign offset = offset_r;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: acquisition, slip, data decode via a
// reference TMDS encoder, timeout and asynchronous reset, with a scoreboard.
module tb_tmds_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] raw;
    logic       de;
    logic [1:0] cd;
    logic [7:0] vd;
    logic       locked;
    logic [3:0] offset;

    tmds_decoder dut (
        .clk    (clk),
        .rst    (rst),
        .raw    (raw),
        .de     (de),
        .cd     (cd),
        .vd     (vd),
        .locked (locked),
        .offset (offset)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;

    typedef struct packed {
        logic       lk;
        logic       de;
        logic [1:0] cd;
        logic [7:0] vd;
        logic [3:0] off;
    } exp_t;

    int         vectors    = 0;
    int         miscompares = 0;
    int         delay      = 0;
    int         disp       = 0;
    logic [9:0] prev_sym   = 10'd0;
    logic [9:0] d0_word;
    logic [7:0] bytes [4]  = '{8'h00, 8'h55, 8'hA3, 8'hFF};
    exp_t       sbq [$];
    logic [15:0] obs_s;

    assign obs_s = {locked, de, cd, vd, offset};

    function automatic exp_t mk(input logic lk, input logic d, input logic [1:0] c,
                                input logic [7:0] v, input logic [3:0] o);
        return {lk, d, c, v, o};
    endfunction

    // Transmit-side TMDS data encoder with running disparity.
    function automatic logic [9:0] tmds_enc(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] q;
        int n1, n1q, n0q;
        n1    = $countones(d);
        qm    = 9'd0;
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (disp == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            disp = disp + (qm[8] ? (n1q - n0q) : (n0q - n1q));
        end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            disp = disp + (qm[8] ? 2 : 0) + (n0q - n1q);
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            disp = disp - (qm[8] ? 0 : 2) + (n1q - n0q);
        end
        return q;
    endfunction

    task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Drive one symbol, serially delayed by 'delay' bits, then sample after the edge.
    task automatic step(input logic [9:0] s);
        logic [19:0] w;
        w        = {s, prev_sym} >> (10 - delay);
        raw      = w[9:0];
        prev_sym = s;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_step(input logic [9:0] s, input exp_t e);
        exp_t f;
        sbq.push_back(e);
        step(s);
        if (sbq.size() == 4) begin
            f = sbq.pop_front();
            check("sb", obs_s, f);
        end
    endtask

    task automatic wait_lock(input logic [9:0] s, input int budget);
        int n;
        n = 0;
        while (locked !== 1'b1 && n < budget) begin
            step(s);
            n++;
        end
        check("lock_wait", {15'd0, locked}, 16'd1);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        disp = 0;
        sbq.delete();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        raw = 10'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", obs_s, 16'h0000);

        // Aligned T00 stream: lock on the 8th evaluated token.
        delay = 0; prev_sym = T00; rst = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step(T00);
            if (i == 10) check("a_prelock", obs_s, mk(1'b0, 1'b0, 2'b00, 8'h00, 4'd0));
            if (i == 11) check("a_lock", obs_s, mk(1'b1, 1'b0, 2'b00, 8'h00, 4'd0));
            if (i == 20) check("a_hold", obs_s, mk(1'b1, 1'b0, 2'b00, 8'h00, 4'd0));
        end

        // Data word injected when cnt=5 in VERIFY.
        reset_dut();
        delay = 0; prev_sym = T00;
        d0_word = tmds_enc(8'h00);
        for (int i = 1; i <= 11; i++) begin
            step((i == 6) ? d0_word : T00);
            if (i == 8)  check("b_verify", obs_s, mk(1'b0, 1'b0, 2'b00, 8'h00, 4'd0));
            if (i == 9)  check("b_slip_adv", obs_s, mk(1'b0, 1'b0, 2'b00, 8'h00, 4'd1));
            if (i == 10) check("b_slip", obs_s, mk(1'b0, 1'b0, 2'b00, 8'h00, 4'd1));
            if (i == 11) check("b_search", obs_s, mk(1'b0, 1'b0, 2'b00, 8'h00, 4'd2));
        end
        wait_lock(T00, 100);
        check("b_relock", obs_s, mk(1'b1, 1'b0, 2'b00, 8'h00, 4'd0));

        // T01 delayed by 3 bits: offset walks 1,1,2,2,3,3 then locks at 3.
        reset_dut();
        delay = 3; prev_sym = T01;
        for (int i = 1; i <= 17; i++) begin
            step(T01);
            if (i >= 4 && i <= 9)
                check("c_offset", obs_s, mk(1'b0, 1'b0, 2'b00, 8'h00, 4'((i - 2) / 2)));
            if (i == 16) check("c_prelock", obs_s, mk(1'b0, 1'b0, 2'b00, 8'h00, 4'd3));
            if (i == 17) check("c_lock", obs_s, mk(1'b1, 1'b0, 2'b01, 8'h00, 4'd3));
        end

        // Encoded data bytes while locked at offset 3.
        for (int i = 0; i < 4; i++) sb_step(T01, mk(1'b1, 1'b0, 2'b01, 8'h00, 4'd3));
        for (int i = 0; i < 4; i++) sb_step(tmds_enc(bytes[i]), mk(1'b1, 1'b1, 2'b01, bytes[i], 4'd3));
        for (int i = 0; i < 12; i++) sb_step(T01, mk(1'b1, 1'b0, 2'b01, 8'h00, 4'd3));

        // Token starvation: lock drops on data word 4096, then relock.
        for (int i = 1; i <= 4096; i++) begin
            if (i < 4096) sb_step(tmds_enc(8'(i)), mk(1'b1, 1'b1, 2'b01, 8'(i), 4'd3));
            else          sb_step(tmds_enc(8'(i)), mk(1'b0, 1'b0, 2'b00, 8'h00, 4'd3));
        end
        for (int j = 1; j <= 11; j++) begin
            if (j < 8) sb_step(T01, mk(1'b0, 1'b0, 2'b00, 8'h00, 4'd3));
            else       sb_step(T01, mk(1'b1, 1'b0, 2'b01, 8'h00, 4'd3));
        end

        // Lock at offset 7, then asynchronous reset and restart from 0.
        reset_dut();
        delay = 7; prev_sym = T10;
        wait_lock(T10, 200);
        check("f_lock7", obs_s, mk(1'b1, 1'b0, 2'b10, 8'h00, 4'd7));
        rst = 1'b0;
        #1;
        check("f_async_clear", obs_s, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        check("f_release", obs_s, 16'h0000);
        for (int i = 1; i <= 4; i++) begin
            step(T10);
            if (i == 3) check("f_restart0", obs_s, mk(1'b0, 1'b0, 2'b00, 8'h00, 4'd0));
            if (i == 4) check("f_restart1", obs_s, mk(1'b0, 1'b0, 2'b00, 8'h00, 4'd1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tmds_decoder.md
TMDS_DECODER -- requirements
Module: tmds_decoder

Interface
REQ-001 SHALL have parameter MIN_TOKENS, default 8: consecutive control tokens at one bit offset required to lock.
REQ-002 SHALL have parameter TIMEOUT, default 4096: words without a control token before lock is dropped; legal only if greater than 800.
REQ-003 clk  input  1  pixel clock; one 10-bit word per cycle.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 raw  input  10  deserialized channel bits at an arbitrary bit offset; raw[0] is the earliest received bit.
REQ-006 de  output  1  registered; 1 when the current symbol is video data.
REQ-007 cd  output  2  registered control data, {vsync,hsync} on the blue channel.
REQ-008 vd  output  8  registered decoded video byte.
REQ-009 locked  output  1  registered; 1 when the state is LOCKED.
REQ-010 offset  output  4  registered current bit-slip offset, range 0..9.

Function
REQ-011 Input pipeline SHALL be r_cur<=raw and r_prev<=r_cur, forming a 20-bit window {r_cur,r_prev}.
REQ-012 The symbol register SHALL be loaded each cycle with sym<=window[offset+9:offset].
REQ-013 Control tokens SHALL be decoded exactly as: 1101010100->cd=00, 0010101011->cd=01, 0101010100->cd=10, 1010101011->cd=11; every other value SHALL be data.
REQ-014 Data decode SHALL be: d = sym[9] ? ~sym[7:0] : sym[7:0]; vd[0]=d[0]; for i=1..7, vd[i] = sym[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
REQ-015 Latency at a fixed offset SHALL be 4 clock edges, from the raw word sampled to the decoded outputs valid.
REQ-016 The state machine SHALL have exactly the states SEARCH, SLIP, VERIFY and LOCKED, and SHALL evaluate sym.
REQ-017 SEARCH: on a token SHALL go to VERIFY with cnt=1; on a non-token SHALL set offset = offset==9 ? 0 : offset+1 and go to SLIP.
REQ-018 SLIP SHALL last exactly one cycle, SHALL ignore sym (still the stale offset), and SHALL return to SEARCH.
REQ-019 VERIFY: on a token SHALL increment cnt, and on reaching MIN_TOKENS SHALL go to LOCKED; on a non-token SHALL advance offset (wrap 9->0) and go to SLIP.
REQ-020 LOCKED SHALL hold offset constant.
REQ-021 LOCKED SHALL reset the timeout counter on every token and increment it otherwise.
REQ-022 LOCKED SHALL go to SEARCH, with offset unchanged, when the timeout counter reaches TIMEOUT.
REQ-023 Data symbols in LOCKED SHALL NOT cause loss of lock.
REQ-024 When not LOCKED, outputs SHALL be de=0, cd=00, vd=00.
REQ-025 When LOCKED and sym is a token, outputs SHALL be de=0, cd=token value, vd=00.
REQ-026 When LOCKED and sym is data, outputs SHALL be de=1, vd=decoded byte, cd holding its last value.
REQ-027 locked SHALL rise in the same cycle as the first LOCKED-state output and SHALL fall on the cycle the state leaves LOCKED.
REQ-028 The cnt and timeout counters SHALL saturate and never wrap.

Reset
REQ-029 Asserting rst (low) SHALL immediately clear r_cur, r_prev, sym, cnt, the timeout counter, offset=0, state=SEARCH, de=0, cd=00, vd=00, locked=0.
REQ-030 Reset asserted mid-lock or mid-search SHALL abandon the current alignment; after release, acquisition SHALL restart from offset 0.
REQ-031 Reset release SHALL be synchronized internally so that the first state update occurs on a clean clock edge.

Verification
REQ-032 Bench: aligned stream (offset 0) of 20 tokens 1101010100 -> locked=1 after exactly 8 token evaluations; offset=0; de=0; cd=00.
REQ-033 Bench: stream of token 0010101011 delayed by 3 bits (raw shifted) -> offset steps 0,1,2,3 with one SLIP cycle per step; locks at offset=3; cd=01.
REQ-034 Bench: after lock, feed words produced by the transmit-side encoder for bytes 0x00, 0x55, 0xA3, 0xFF -> de=1 and vd reproduces each byte 4 edges after input.
REQ-035 Bench: after lock, 4096 consecutive data words with no token -> locked falls on word 4096; de=0; offset retained; relock after 8 tokens.
REQ-036 Bench: during VERIFY with cnt=5, inject one data word -> offset advances by 1, SLIP, then SEARCH; locked stays 0.
REQ-037 Bench: assert rst low while locked at offset=7 -> all outputs cleared asynchronously; after release, offset=0 and the search restarts.
